// File: rtl/sdram_pkg.sv
// sdram_pkg: shared SDRAM command encodings, idle-bus constants and the
// arbiter state encoding used by sdram_arbiter and sdram_arb_cmd_mux.
// Commands are {CS#, RAS#, CAS#, WE#}.
package sdram_pkg;

   localparam logic [3:0] CMD_NOP  = 4'b0111;
   localparam logic [3:0] CMD_ACT  = 4'b0011;
   localparam logic [3:0] CMD_RD   = 4'b0101;
   localparam logic [3:0] CMD_WR   = 4'b0100;
   localparam logic [3:0] CMD_PRE  = 4'b0010;
   localparam logic [3:0] CMD_AREF = 4'b0001;
   localparam logic [3:0] CMD_BST  = 4'b0110;

   // Idle bus values for the default 2-bit bank / 13-bit address build.
   // The mux uses width-generic all-ones so other widths follow suit.
   localparam logic [1:0]  NOP_BANK = 2'b11;
   localparam logic [12:0] NOP_ADDR = 13'h1fff;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARBIT = 3'd1,
      ST_AREF  = 3'd2,
      ST_WRITE = 3'd3,
      ST_READ  = 3'd4
   } arb_state_t;

endpackage

// File: rtl/sdram_arb_cmd_mux.sv
// sdram_arb_cmd_mux: combinational pin mux for the SDRAM arbiter.
// Selects the granted engine's cmd/bank/addr from the arbiter state and
// drives the DQ output path for the write engine.
// Ports:
//   force_idle          in   hold pins at NOP/idle values (reset)
//   state               in   arbiter state
//   init/aref/wr/rd_*   in   engine cmd/bank/addr buses
//   wr_sdram_en/data    in   write engine DQ drive request and data
//   cmd/ba/addr         out  muxed SDRAM command/bank/address
//   dq_out/dq_oe        out  DQ data and output enable
module sdram_arb_cmd_mux
   import sdram_pkg::*;
#(
   parameter int BANK_W = 2,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              force_idle,
   input  arb_state_t        state,
   input  logic [3:0]        init_cmd,
   input  logic [BANK_W-1:0] init_bank,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [3:0]        aref_cmd,
   input  logic [BANK_W-1:0] aref_bank,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic [3:0]        wr_cmd,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3:0]        rd_cmd,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_sdram_en,
   input  logic [DATA_W-1:0] wr_sdram_data,
   output logic [3:0]        cmd,
   output logic [BANK_W-1:0] ba,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] dq_out,
   output logic              dq_oe
);

   always_comb begin
      cmd  = CMD_NOP;
      ba   = '1;
      addr = '1;
      if (!force_idle) begin
         case (state)
            ST_IDLE: begin
               cmd  = init_cmd;
               ba   = init_bank;
               addr = init_addr;
            end
            ST_AREF: begin
               cmd  = aref_cmd;
               ba   = aref_bank;
               addr = aref_addr;
            end
            ST_WRITE: begin
               cmd  = wr_cmd;
               ba   = wr_bank;
               addr = wr_addr;
            end
            ST_READ: begin
               cmd  = rd_cmd;
               ba   = rd_bank;
               addr = rd_addr;
            end
            // ARBIT and any illegal encoding park the bus on NOP
            default: begin
               cmd  = CMD_NOP;
               ba   = '1;
               addr = '1;
            end
         endcase
      end
   end

   assign dq_oe  = !force_idle && (state == ST_WRITE) && wr_sdram_en;
   assign dq_out = dq_oe ? wr_sdram_data : '0;

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the SDRAM command/data bus between the init,
// auto-refresh, write and read engines. The init engine owns the bus until
// init_end; afterwards one engine is granted at a time with a NOP cycle
// between grants. Refresh always has highest priority, no pre-emption.
// Optional macro SDRAM_ARB_RR_EN: write/read share round-robin priority;
// otherwise fixed priority aref > write > read.
// Ports:
//   arb_clk, arb_rst            clock, async active-high reset
//   init_end, init_*            init engine done flag and bus
//   aref_/wr_/rd_ req,end,bus   engine requests, end pulses and buses
//   wr_sdram_en, wr_sdram_data  write engine DQ drive
//   aref_en, wr_en, rd_en       grants
//   sdram_*                     SDRAM pins (DQ tristate is outside)
//
// state | meaning
// IDLE  | init engine owns the bus, waiting for init_end
// ARBIT | NOP bubble, choose next engine
// AREF  | refresh engine granted until aref_end
// WRITE | write engine granted until wr_end
// READ  | read engine granted until rd_end
module sdram_arbiter
   import sdram_pkg::*;
#(
   parameter int BANK_W = 2,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16
) (
   input  logic              arb_clk,
   input  logic              arb_rst,
   input  logic              init_end,
   input  logic [3:0]        init_cmd,
   input  logic [BANK_W-1:0] init_bank,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic              aref_req,
   input  logic              aref_end,
   input  logic [3:0]        aref_cmd,
   input  logic [BANK_W-1:0] aref_bank,
   input  logic [ADDR_W-1:0] aref_addr,
   input  logic              wr_req,
   input  logic              wr_end,
   input  logic [3:0]        wr_cmd,
   input  logic [BANK_W-1:0] wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              wr_sdram_en,
   input  logic [DATA_W-1:0] wr_sdram_data,
   input  logic              rd_req,
   input  logic              rd_end,
   input  logic [3:0]        rd_cmd,
   input  logic [BANK_W-1:0] rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic              sdram_cke,
   output logic              sdram_cs_n,
   output logic              sdram_ras_n,
   output logic              sdram_cas_n,
   output logic              sdram_we_n,
   output logic [BANK_W-1:0] sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic [DATA_W-1:0] sdram_dq_out,
   output logic              sdram_dq_oe
);

   arb_state_t state;
   logic [3:0] pin_cmd;

`ifdef SDRAM_ARB_RR_EN
   // 1 = read was served last, so write wins the next tie
   logic last_grant;
`endif

   always_ff @(posedge arb_clk or posedge arb_rst) begin
      if (arb_rst) begin
         state <= ST_IDLE;
`ifdef SDRAM_ARB_RR_EN
         last_grant <= 1'b1;
`endif
      end else begin
         case (state)
            ST_IDLE: if (init_end) state <= ST_ARBIT;
            ST_ARBIT: begin
               if (!init_end)
                  state <= ST_IDLE;
               else if (aref_req)
                  state <= ST_AREF;
`ifdef SDRAM_ARB_RR_EN
               else if (wr_req && (!rd_req || last_grant)) begin
                  state      <= ST_WRITE;
                  last_grant <= 1'b0;
               end else if (rd_req) begin
                  state      <= ST_READ;
                  last_grant <= 1'b1;
               end
`else
               else if (wr_req)
                  state <= ST_WRITE;
               else if (rd_req)
                  state <= ST_READ;
`endif
            end
            ST_AREF:  if (aref_end) state <= ST_ARBIT;
            ST_WRITE: if (wr_end)   state <= ST_ARBIT;
            ST_READ:  if (rd_end)   state <= ST_ARBIT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   assign aref_en   = (state == ST_AREF);
   assign wr_en     = (state == ST_WRITE);
   assign rd_en     = (state == ST_READ);
   assign sdram_cke = 1'b1;

   sdram_arb_cmd_mux #(
      .BANK_W (BANK_W),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmd_mux (
      .force_idle    (arb_rst),
      .state         (state),
      .init_cmd      (init_cmd),
      .init_bank     (init_bank),
      .init_addr     (init_addr),
      .aref_cmd      (aref_cmd),
      .aref_bank     (aref_bank),
      .aref_addr     (aref_addr),
      .wr_cmd        (wr_cmd),
      .wr_bank       (wr_bank),
      .wr_addr       (wr_addr),
      .rd_cmd        (rd_cmd),
      .rd_bank       (rd_bank),
      .rd_addr       (rd_addr),
      .wr_sdram_en   (wr_sdram_en),
      .wr_sdram_data (wr_sdram_data),
      .cmd           (pin_cmd),
      .ba            (sdram_ba),
      .addr          (sdram_addr),
      .dq_out        (sdram_dq_out),
      .dq_oe         (sdram_dq_oe)
   );

   assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

endmodule
